// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the register list of an ARM block
// data-transfer instruction. Optional base write-back: define LDM_STM_WRITEBACK_EN.
module ldm_stm_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [31:0] IR,
  input  logic [31:0] BASE,
  input  logic        MFC,
  output logic        BUSY,
  output logic        DONE,
  output logic        MEM_EN,
  output logic        MEM_RW,
  output logic [31:0] ADDR,
  output logic [3:0]  REG_NUM,
  output logic        RF_LD,
  output logic        WB_EN,
  output logic [31:0] WB_VALUE
);

  // Memory handshake: an access is offered while MEM_EN=1 and completes in the
  // cycle MFC=1; everything the access presents is held until then.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    XFER   = 3'd2,
    NEXT   = 3'd3,
    WBACK  = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] list_q, list_d;
  logic        pre_q, pre_d;
  logic        up_q, up_d;
  logic        load_q, load_d;
  logic [31:0] base_q, base_d;
  logic [31:0] addr_q, addr_d;

`ifdef LDM_STM_WRITEBACK_EN
  logic        wback_q, wback_d;
  logic [31:0] wb_value_q, wb_value_d;
`endif

  logic [3:0]  cur_reg;
  logic [15:0] list_rest;
  logic [31:0] four_n;
  logic        is_block;
  logic        unused_ir;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  assign is_block  = (IR[27:25] == 3'b100);
  assign four_n    = {25'd0, popcount16(list_q), 2'b00};
  assign list_rest = list_q & (list_q - 16'd1);
  assign cur_reg   = lowest_set(list_q);

`ifdef LDM_STM_WRITEBACK_EN
  assign unused_ir = ^{IR[31:28], IR[22], IR[19:16]};
`else
  assign unused_ir = ^{IR[31:28], IR[22:21], IR[19:16]};
`endif

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    pre_d   = pre_q;
    up_d    = up_q;
    load_d  = load_q;
    base_d  = base_q;
    addr_d  = addr_q;
`ifdef LDM_STM_WRITEBACK_EN
    wback_d    = wback_q;
    wb_value_d = wb_value_q;
`endif
    case (state_q)
      IDLE: begin
        if (START && is_block) begin
          list_d  = IR[15:0];
          pre_d   = IR[24];
          up_d    = IR[23];
          load_d  = IR[20];
          base_d  = BASE;
`ifdef LDM_STM_WRITEBACK_EN
          wback_d = IR[21];
`endif
          state_d = SETUP;
        end
      end
      SETUP: begin
        // Every mode is turned into an ascending walk from the lowest address.
        case ({pre_q, up_q})
          2'b01:   addr_d = base_q;
          2'b11:   addr_d = base_q + 32'd4;
          2'b00:   addr_d = base_q - four_n + 32'd4;
          default: addr_d = base_q - four_n;
        endcase
`ifdef LDM_STM_WRITEBACK_EN
        wb_value_d = up_q ? (base_q + four_n) : (base_q - four_n);
`endif
        state_d = (list_q == 16'd0) ? FINISH : XFER;
      end
      XFER: begin
        if (MFC) begin
          list_d = list_rest;
          addr_d = addr_q + 32'd4;
          if (list_rest != 16'd0) begin
            state_d = NEXT;
          end else begin
`ifdef LDM_STM_WRITEBACK_EN
            state_d = wback_q ? WBACK : FINISH;
`else
            state_d = FINISH;
`endif
          end
        end
      end
      NEXT:    state_d = XFER;
`ifdef LDM_STM_WRITEBACK_EN
      WBACK:   state_d = FINISH;
`endif
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      list_q  <= 16'd0;
      pre_q   <= 1'b0;
      up_q    <= 1'b0;
      load_q  <= 1'b0;
      base_q  <= 32'd0;
      addr_q  <= 32'd0;
`ifdef LDM_STM_WRITEBACK_EN
      wback_q    <= 1'b0;
      wb_value_q <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      pre_q   <= pre_d;
      up_q    <= up_d;
      load_q  <= load_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
`ifdef LDM_STM_WRITEBACK_EN
      wback_q    <= wback_d;
      wb_value_q <= wb_value_d;
`endif
    end
  end

  always_comb begin
    BUSY     = (state_q != IDLE);
    DONE     = 1'b0;
    MEM_EN   = 1'b0;
    MEM_RW   = 1'b0;
    ADDR     = 32'd0;
    REG_NUM  = 4'd0;
    WB_EN    = 1'b0;
    WB_VALUE = 32'd0;
    case (state_q)
      XFER: begin
        MEM_EN  = 1'b1;
        MEM_RW  = load_q;
        ADDR    = addr_q;
        REG_NUM = cur_reg;
      end
      NEXT: begin
        ADDR    = addr_q;
        REG_NUM = cur_reg;
      end
`ifdef LDM_STM_WRITEBACK_EN
      WBACK: begin
        WB_EN    = 1'b1;
        WB_VALUE = wb_value_q;
      end
`endif
      FINISH:  DONE = 1'b1;
      default: ;
    endcase
    RF_LD = MEM_EN & MEM_RW & MFC;
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: a list-level reference model predicts
// accesses, write-back and DONE cycle; a negedge monitor pops and compares.
module tb_ldm_stm_sequencer;

`ifdef LDM_STM_WRITEBACK_EN
  localparam bit WB_ON = 1'b1;
`else
  localparam bit WB_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, START, MFC;
  logic [31:0] IR, BASE;
  logic        BUSY, DONE, MEM_EN, MEM_RW, RF_LD, WB_EN;
  logic [31:0] ADDR, WB_VALUE;
  logic [3:0]  REG_NUM;

  ldm_stm_sequencer dut (
    .CLK(CLK), .RESET(RESET), .START(START), .IR(IR), .BASE(BASE), .MFC(MFC),
    .BUSY(BUSY), .DONE(DONE), .MEM_EN(MEM_EN), .MEM_RW(MEM_RW), .ADDR(ADDR),
    .REG_NUM(REG_NUM), .RF_LD(RF_LD), .WB_EN(WB_EN), .WB_VALUE(WB_VALUE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [36:0] exp_acc_q[$];   // {rw, reg, addr}
  logic [31:0] exp_wb_q[$];
  logic [31:0] exp_done_q[$];  // cycle count at which DONE is due
  int          wait_q[$];      // MFC wait cycles per access

  bit mon_en   = 1'b0;
  bit hold_mfc = 1'b0;

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_block_ir();
    logic [31:0] r;
    r = $urandom;
    r[27:25] = 3'b100;
    case ($urandom_range(0, 4))
      0:       r[15:0] = 16'(1 << $urandom_range(0, 15));
      1:       r[15:0] = 16'h0000;
      2:       r[15:0] = 16'hFFFF;
      default: ;
    endcase
    return r;
  endfunction

  // ---------------- memory responder ----------------
  bit in_acc    = 1'b0;
  int wait_left = 0;
  initial begin
    MFC = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (hold_mfc) begin
        MFC = 1'b0;
      end else if (MEM_EN) begin
        if (!in_acc) begin
          in_acc    = 1'b1;
          wait_left = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
        end
        if (wait_left == 0) begin
          MFC    = 1'b1;
          in_acc = 1'b0;
        end else begin
          MFC = 1'b0;
          wait_left--;
        end
      end else begin
        MFC = 1'($urandom_range(0, 1));  // must be ignored outside XFER
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [36:0] ea;
  logic [31:0] ew, ed;
  always @(negedge CLK) begin
    if (mon_en) begin
      if (MEM_EN && MFC) begin
        check("acc_pending", 73'(exp_acc_q.size() != 0), 73'(1));
        if (exp_acc_q.size() != 0) begin
          ea = exp_acc_q.pop_front();
          check("acc_rw_reg_addr", 73'({MEM_RW, REG_NUM, ADDR}), 73'(ea));
          check("acc_rf_ld", 73'(RF_LD), 73'(ea[36]));
        end
      end
      if (MEM_EN && !MFC) check("wait_rf_ld", 73'(RF_LD), 73'(0));
      if (WB_EN) begin
        check("wb_pending", 73'(exp_wb_q.size() != 0), 73'(1));
        if (exp_wb_q.size() != 0) begin
          ew = exp_wb_q.pop_front();
          check("wb_value", 73'(WB_VALUE), 73'(ew));
        end
      end
      if (DONE) begin
        check("done_pending", 73'(exp_done_q.size() != 0), 73'(1));
        if (exp_done_q.size() != 0) begin
          ed = exp_done_q.pop_front();
          check("done_cycle", 73'(cyc), 73'(ed));
        end
        check("done_quiet", 73'({MEM_EN, WB_EN, REG_NUM, ADDR}), 73'(0));
      end
      if (!BUSY)
        check("idle_zero", 73'({DONE, MEM_EN, MEM_RW, RF_LD, WB_EN, REG_NUM, ADDR, WB_VALUE}), 73'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_raw(input logic [31:0] ir, input logic [31:0] base);
    @(posedge CLK);
    #1;
    START = 1'b1;
    IR    = ir;
    BASE  = base;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  // Reference model: registers in ascending order at ascending word addresses
  // from the mode's lowest address; DONE after 2N+2 cycles + waits + write-back.
  task automatic issue(input logic [31:0] ir, input logic [31:0] base, input int max_wait);
    int          n, sum_w, w, lat, c0, guard;
    bit          wb;
    logic [31:0] four_n, a;
    n = 0;
    for (int r = 0; r < 16; r++) if (ir[r]) n++;
    four_n = 32'(4 * n);
    case ({ir[24], ir[23]})
      2'b01:   a = base;
      2'b11:   a = base + 32'd4;
      2'b00:   a = base - four_n + 32'd4;
      default: a = base - four_n;
    endcase
    sum_w = 0;
    for (int r = 0; r < 16; r++) begin
      if (ir[r]) begin
        exp_acc_q.push_back({ir[20], 4'(r), a});
        a = a + 32'd4;
        w = $urandom_range(0, max_wait);
        wait_q.push_back(w);
        sum_w += w;
      end
    end
    wb = WB_ON && ir[21] && (n > 0);
    if (wb) exp_wb_q.push_back(ir[23] ? (base + four_n) : (base - four_n));
    lat = (n == 0) ? 3 : (2 * n + 2 + sum_w + int'(wb));
    @(posedge CLK);
    #1;
    START = 1'b1;
    IR    = ir;
    BASE  = base;
    c0    = cyc;
    exp_done_q.push_back(32'(c0 + lat - 1));
    @(posedge CLK);
    #1;
    START = 1'b0;
    guard = 0;
    forever begin
      @(negedge CLK);
      if (!BUSY) break;
      guard++;
      if (guard > 500) begin
        check("busy_timeout", 73'(BUSY), 73'(0));
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        exp_acc_q.delete();
        exp_wb_q.delete();
        exp_done_q.delete();
        wait_q.delete();
        break;
      end
      @(posedge CLK);
      #1;
      // Stray STARTs and input churn while busy must not disturb the transfer.
      START = ($urandom_range(0, 5) == 0);
      IR    = rand_block_ir();
      BASE  = $urandom;
    end
    START = 1'b0;
  endtask

  task automatic reset_in_xfer();
    int guard;
    hold_mfc = 1'b1;
    start_raw(32'hE8B000F0, 32'h0000_1000);
    guard = 0;
    while (!MEM_EN && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    check("hold_mem_en", 73'(MEM_EN), 73'(1));
    repeat (3) begin
      @(negedge CLK);
      check("hold_stable", 73'({MEM_EN, MEM_RW, RF_LD, REG_NUM, ADDR}), 73'({1'b1, 1'b1, 1'b0, 4'd4, 32'h0000_1000}));
    end
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    START = 1'b1;
    IR    = 32'hE8B0_0003;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    START = 1'b0;
    @(negedge CLK);
    check("reset_abort_zero",
          73'({BUSY, DONE, MEM_EN, MEM_RW, RF_LD, WB_EN, REG_NUM, ADDR, WB_VALUE}), 73'(0));
    hold_mfc = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      check("reset_abort_idle", 73'(BUSY), 73'(0));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] bad_ir;
    int          op;
    RESET = 1'b1;
    START = 1'b0;
    IR    = 32'd0;
    BASE  = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    mon_en = 1'b1;
    check("reset_state",
          73'({BUSY, DONE, MEM_EN, MEM_RW, RF_LD, WB_EN, REG_NUM, ADDR, WB_VALUE}), 73'(0));

    issue(32'hE8B0_0007, 32'h0000_0100, 0);  // LDMIA W=1 {R0-R2}
    issue(32'hE900_8001, 32'h0000_0200, 2);  // STMDB {R0,R15}
    issue(32'hE8B0_0000, 32'h0000_0300, 0);  // empty list

    for (int k = 0; k < 4; k++) begin
      bad_ir = $urandom;
      op = $urandom_range(0, 6);
      if (op >= 4) op++;
      bad_ir[27:25] = 3'(op);
      start_raw(bad_ir, $urandom);
      @(negedge CLK);
      check("bad_opcode_idle", 73'(BUSY), 73'(0));
    end

    reset_in_xfer();
    issue(32'hE830_0003, 32'h0000_0000, 1);  // LDMDA W=1 wrapping below zero

    for (int k = 0; k < 40; k++) issue(rand_block_ir(), $urandom, 3);

    repeat (5) @(negedge CLK);
    check("acc_q_drained", 73'(exp_acc_q.size()), 73'(0));
    check("wb_q_drained", 73'(exp_wb_q.size()), 73'(0));
    check("done_q_drained", 73'(exp_done_q.size()), 73'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_failed %0d", tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
